// File: rtl/rgb_matrix_scan_ctrl.sv
// Row-scan scheduler for an 8x8 common-row RGB matrix with ping-pong frame banks.
// Swaps the front and back banks only at the frame boundary, after a request/acknowledge handshake.
module rgb_matrix_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 12500,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] OR,
    output logic [7:0] OG,
    output logic [7:0] OB,
    output logic [2:0] s,
    output logic       EN
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                        : BLANK_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    // state_q/cnt_q/row_q describe the cycle the output registers will present next.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       row_q;
    logic             front_q;
    logic             swap_pending_q;
    logic [7:0]       bank_q [2][8][3];

    logic boundary;
    logic swap_now;
    logic wr_accept;

    always_comb begin
        // Outputs show the last DRIVE cycle of row 7 while row 0 BLANK is queued next.
        boundary  = EN && (state_q == StBlank) && (cnt_q == '0) && (row_q == 3'd0);
        swap_now  = boundary && (swap_pending_q || swap_req);
        wr_accept = wr_en && wr_ready && (wr_color != 2'd3);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= StBlank;
            cnt_q          <= '0;
            row_q          <= 3'd0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_ready       <= 1'b1;
            swap_ack       <= 1'b0;
            frame_start    <= 1'b0;
            OR             <= 8'hFF;
            OG             <= 8'hFF;
            OB             <= 8'hFF;
            s              <= 3'd0;
            EN             <= 1'b0;
        end else begin
            s           <= row_q;
            frame_start <= (state_q == StBlank) && (cnt_q == '0) && (row_q == 3'd0);
            swap_ack    <= swap_now;

            if (state_q == StDrive) begin
                EN <= 1'b1;
                OR <= bank_q[front_q][row_q][0];
                OG <= bank_q[front_q][row_q][1];
                OB <= bank_q[front_q][row_q][2];
            end else begin
                EN <= 1'b0;
                OR <= 8'hFF;
                OG <= 8'hFF;
                OB <= 8'hFF;
            end

            unique case (state_q)
                StBlank: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= StDrive;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        row_q   <= row_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase

            if (swap_now) begin
                front_q        <= ~front_q;
                swap_pending_q <= 1'b0;
                wr_ready       <= 1'b1;
            end else if (swap_req) begin
                swap_pending_q <= 1'b1;
                wr_ready       <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        bank_q[b][r][c] <= 8'hFF;
                    end
                end
            end
        end else if (wr_accept) begin
            bank_q[~front_q][wr_row][wr_color] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rgb_matrix_scan_ctrl.sv
// Directed bench for rgb_matrix_scan_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
module tb_rgb_matrix_scan_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [1:0] wr_color = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       swap_req = 1'b0;
    logic       wr_ready;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] OR;
    logic [7:0] OG;
    logic [7:0] OB;
    logic [2:0] s;
    logic       EN;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PR3    = 64'hFFFF_FFFF_0FFF_FFFF;  // row 3 = 8'h0F
    localparam logic [63:0] PB2    = 64'hFFFF_FFFF_FF55_FFFF;  // row 2 = 8'h55
    localparam logic [29:0] RST_VEC = {8'hFF, 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};

    logic [29:0] dut_vec;
    assign dut_vec = {OR, OG, OB, EN, s, frame_start, swap_ack};

    rgb_matrix_scan_ctrl #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_color   (wr_color),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .OR         (OR),
        .OG         (OG),
        .OB         (OB),
        .s          (s),
        .EN         (EN)
    );

    always #5 CLK = ~CLK;

    // Expected {OR,OG,OB,EN,s,frame_start,swap_ack} at frame position p (0..47).
    function automatic logic [29:0] exp_vec(input int p, input logic [63:0] pr,
                                            input logic [63:0] pg, input logic [63:0] pb,
                                            input logic ack);
        int row;
        int ph;
        logic en;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        row = p / 6;
        ph  = p % 6;
        en  = (ph >= 2);
        r   = en ? pr[row*8 +: 8] : 8'hFF;
        g   = en ? pg[row*8 +: 8] : 8'hFF;
        b   = en ? pb[row*8 +: 8] : 8'hFF;
        return {r, g, b, en, 3'(row), (p == 0), (p == 0) && ack};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b1; wr_row = 3'd1; wr_color = 2'd0; wr_data = 8'h00;
        swap_req = 1'b1;
        step();
        step();
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec, RST_VEC);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
        end
        wr_en = 1'b0;
        swap_req = 1'b0;
        reset = 1'b0;
        step();
        cyc = 0;
    endtask

    task automatic test_idle_scan();
        logic [29:0] e;
        while (cyc < 96) begin
            e = exp_vec(cyc % 48, ALL_FF, ALL_FF, ALL_FF, 1'b0);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL idle_scan cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_wr_ready cyc=%0d got=%b exp=1", cyc, wr_ready);
            end
            step();
        end
    endtask

    task automatic test_write_swap();
        logic [29:0] e;
        wr_en = 1'b1; wr_row = 3'd3; wr_color = 2'd0; wr_data = 8'h0F;
        step();
        wr_row = 3'd0; wr_color = 2'd3; wr_data = 8'h00;   // reserved plane
        step();
        wr_en = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_drop cyc=%0d got=%b exp=0", cyc, wr_ready);
        end
        wr_en = 1'b1; wr_row = 3'd0; wr_color = 2'd1; wr_data = 8'h00;   // must be dropped
        step();
        wr_en = 1'b0;
        while (cyc < 144) begin
            e = exp_vec(cyc % 48, ALL_FF, ALL_FF, ALL_FF, 1'b0);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL pending_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL pending_wr_ready cyc=%0d got=%b exp=0", cyc, wr_ready);
            end
            step();
        end
        while (cyc < 192) begin
            e = exp_vec(cyc % 48, PR3, ALL_FF, ALL_FF, 1'b1);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL swapped_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            if (cyc == 144) begin
                checks++;
                if (wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_ready_restore cyc=%0d got=%b exp=1", cyc, wr_ready);
                end
                // Back-bank write while bank 1 is on display.
                wr_en = 1'b1; wr_row = 3'd2; wr_color = 2'd2; wr_data = 8'h55;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_boundary_swap();
        logic [29:0] e;
        while (cyc < 240) begin
            e = exp_vec(cyc % 48, PR3, ALL_FF, ALL_FF, 1'b0);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL hold_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            swap_req = (cyc == 239);
            step();
        end
        swap_req = 1'b0;
        checks++;
        if (swap_ack !== 1'b1) begin
            errors++;
            $display("FAIL late_swap_ack cyc=%0d got=%b exp=1", cyc, swap_ack);
        end
        while (cyc < 288) begin
            e = exp_vec(cyc % 48, ALL_FF, ALL_FF, PB2, 1'b1);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL bank0_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            if (cyc == 251) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL second_pending cyc=%0d got=%b exp=0", cyc, wr_ready);
                end
            end
            swap_req = (cyc == 250) || (cyc == 260);
            step();
        end
        swap_req = 1'b0;
    endtask

    task automatic test_ping_pong();
        logic [29:0] e;
        while (cyc < 336) begin
            e = exp_vec(cyc % 48, PR3, ALL_FF, ALL_FF, 1'b1);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL ping_pong cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [29:0] e;
        logic        rdy;
        while (cyc < 369) begin
            e = exp_vec(cyc % 48, PR3, ALL_FF, ALL_FF, 1'b0);
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL no_requeue cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            swap_req = (cyc == 340);
            step();
        end
        swap_req = 1'b0;
        e = exp_vec(33, PR3, ALL_FF, ALL_FF, 1'b0);
        checks++;
        if (dut_vec !== e) begin
            errors++;
            $display("FAIL row5_drive cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_pending got=%b exp=0", wr_ready);
        end
        reset = 1'b1;
        step();
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL midreset_outputs got=%h exp=%h", dut_vec, RST_VEC);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_wr_ready got=%b exp=1", wr_ready);
        end
        reset = 1'b0;
        step();
        cyc = 0;
        // Both banks were cleared; a fresh swap in frame 0 shows the other bank blank too.
        while (cyc < 96) begin
            e = exp_vec(cyc % 48, ALL_FF, ALL_FF, ALL_FF, cyc >= 48);
            rdy = !((cyc >= 11) && (cyc < 48));
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            checks++;
            if (wr_ready !== rdy) begin
                errors++;
                $display("FAIL post_reset_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, rdy);
            end
            swap_req = (cyc == 10);
            step();
        end
        swap_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_write_swap();
        test_boundary_swap();
        test_ping_pong();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_matrix_scan_ctrl.md
Name: rgb_matrix_scan_ctrl

Overview:
Row-scan scheduler for the 8x8 common-row RGB LED matrix. It owns two ping-pong frame banks: game logic writes the back bank, and the scanner reads the front bank. The block sequences row select, column drive and anti-ghost blanking, and swaps banks only at a frame boundary after a request/acknowledge handshake. It replaces ad-hoc row counters on divided clocks with a single-clock, enable-counted scan.

Parameters:
DWELL_CYCLES, 12500, CLK cycles each row is driven (>=1)
BLANK_CYCLES, 16, CLK cycles all columns are off before each row (>=1)

Ports:
CLK  in  1  system clock; the only clock in the block
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for the back bank
wr_row  in  3  row index of the write
wr_color  in  2  plane select: 0=R, 1=G, 2=B, 3=reserved (write ignored)
wr_data  in  8  column pattern, active-low (0 = LED on)
wr_ready  out  1  high when writes are accepted (no swap pending)
swap_req  in  1  one-cycle pulse requesting a back/front swap
swap_ack  out  1  one-cycle pulse in the cycle the swap takes effect
frame_start  out  1  one-cycle pulse when the row-0 BLANK phase begins
OR  out  8  red column drive, active-low
OG  out  8  green column drive, active-low
OB  out  8  blue column drive, active-low
s  out  3  current row select
EN  out  1  row-driver enable; 1 only during the DRIVE phase

Behaviour:
- Reset state (synchronous, wins over all other inputs in the same cycle):
  - all 48 bytes of both banks = 8'hFF; front = bank 0
  - OR/OG/OB = 8'hFF; s = 0; EN = 0
  - state = BLANK; counter = 0; swap_pending = 0
  - wr_ready = 1; swap_ack = 0; frame_start = 0
- FSM, two states:
  - BLANK: OR/OG/OB = 8'hFF, EN = 0. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: OR/OG/OB = front[s] R/G/B, EN = 1. After DWELL_CYCLES cycles, go to BLANK and set s = s+1 (mod 8).
- All outputs are registered. Row data is valid in the first DRIVE cycle; there is no intermediate pipeline bubble.
- Frame period = 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- frame_start pulses in the first BLANK cycle of row 0, including the first BLANK after reset release.
- Write path:
  - When wr_en && wr_ready && wr_color!=3, back[wr_row][wr_color] <= wr_data, visible to the next read after this edge.
  - Writes never touch the front bank.
  - A write with wr_ready=0 or wr_color=3 is dropped silently.
- Swap handshake:
  - swap_req sets swap_pending; wr_ready = ~swap_pending.
  - swap_req while already pending has no additional effect; requests are not queued.
  - Boundary = the last DRIVE cycle of row 7. If (swap_pending | swap_req) at the boundary, front/back toggle at that edge, swap_ack pulses on the following cycle (the first BLANK of row 0, same cycle as frame_start), and swap_pending clears.
  - swap_req coincident with the boundary is honored in that frame.
- After a swap, the back bank holds the previous front contents; there is no auto-copy or clear.
- The front bank never changes mid-frame. Each displayed frame comes from exactly one bank.
- reset asserted mid-frame: next cycle matches the reset state; any pending swap is discarded.
- Counter width is $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). Comparisons use counter == N-1, then clear to 0.

Test Plan:
(Use DWELL_CYCLES=4, BLANK_CYCLES=2; frame = 48 cycles.)
1. Reset, then idle -> OR/OG/OB = 8'hFF throughout. EN high on cycles 2-5, 8-11, ... after reset release. s steps 0..7 then wraps to 0. frame_start pulses every 48 cycles starting at cycle 0.
2. Write R row 3 = 8'h0F, then swap_req -> wr_ready drops next cycle. swap_ack coincides with the next frame_start. OR = 8'h0F only during row-3 DRIVE of following frames; OR = 8'hFF on other rows.
3. swap_req pulsed in the row-7 last DRIVE cycle -> swap_ack in the immediately following cycle, not one frame later.
4. Write with wr_ready=0 (G row 0 = 8'h00), and a write with wr_color=3 -> neither ever appears. After a subsequent swap, OG row 0 = 8'hFF.
5. Two swaps in consecutive frames with no intervening writes -> display returns to the original pattern (ping-pong, no auto-copy).
6. Assert reset during row-5 DRIVE with swap pending -> next cycle OR/OG/OB = 8'hFF, s = 0, EN = 0, wr_ready = 1. No swap_ack is ever issued for the discarded request.
